// File: rtl/sa_tile_sequencer_if.sv
// Stream bundle for the tile sequencer: A/W beat input and drained result rows.
// The sequencer takes the slave side of both streams; the environment takes master.
interface sa_tile_sequencer_if #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned INWIDTH  = 8,
  parameter int unsigned OUTWIDTH = 32
);
  logic [ROWS*INWIDTH-1:0]  in_a;
  logic [COLS*INWIDTH-1:0]  in_w;
  logic                     in_valid;
  logic                     in_ready;
  logic [COLS*OUTWIDTH-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output in_a, in_w, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_a, in_w, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Tile controller for an output-stationary systolic array: clear, skewed feed,
// wavefront flush, then row-by-row drain over ready/valid.
module sa_tile_sequencer #(
  parameter  int unsigned ROWS     = 8,
  parameter  int unsigned COLS     = 8,
  parameter  int unsigned INWIDTH  = 8,
  parameter  int unsigned OUTWIDTH = 32,
  parameter  int unsigned KMAX     = 256,
  localparam int unsigned KW       = $clog2(KMAX + 1),
  localparam int unsigned RW       = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     arr_fire,
  output logic                     arr_clr,
  output logic [ROWS*INWIDTH-1:0]  arr_a,
  output logic [COLS*INWIDTH-1:0]  arr_w,
  output logic [RW-1:0]            arr_row_sel,
  input  logic [COLS*OUTWIDTH-1:0] arr_row_data,
  sa_tile_sequencer_if.slave       bus
);
  localparam int unsigned    FW         = $clog2(ROWS + COLS);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN} state_t;

  state_t                   r_state, w_state_nxt;
  logic [KW-1:0]            r_klen, r_beat;
  logic [FW-1:0]            r_flush;
  logic [RW-1:0]            r_row;
  logic                     r_all_issued;
  logic [COLS*OUTWIDTH-1:0] r_out_data;
  logic                     r_out_valid, r_out_last;
  logic                     r_done, r_err;
  logic                     w_klen_ok, w_last_beat, w_load, w_drain_end;
  logic                     w_in_ready, w_fire, w_clr;

  assign w_klen_ok   = (k_len != '0) && (k_len <= KW'(KMAX));
  assign w_last_beat = (r_beat + KW'(1)) == r_klen;
  assign w_drain_end = (r_state == S_DRAIN) && r_out_valid && bus.out_ready && r_out_last;
  assign w_load      = (r_state == S_DRAIN) && !r_all_issued && (!r_out_valid || bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_fire      = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE:  if (start && w_klen_ok) w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        w_clr       = 1'b1;
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        w_in_ready = 1'b1;
        w_fire     = bus.in_valid;
        if (bus.in_valid && w_last_beat) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_fire = 1'b1;
        if (r_flush == FLUSH_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_drain_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      r_klen       <= '0;
      r_beat       <= '0;
      r_flush      <= '0;
      r_row        <= '0;
      r_all_issued <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_klen_ok) r_klen <= k_len;
          else           r_err  <= 1'b1;
        end
        S_FEED: if (bus.in_valid) r_beat <= w_last_beat ? '0 : r_beat + KW'(1);
        S_FLUSH: r_flush <= (r_flush == FLUSH_LAST) ? '0 : r_flush + FW'(1);
        S_DRAIN: begin
          // Output register refills in the same cycle it is consumed, so a held-high
          // out_ready gives one row per cycle without a bubble.
          if (w_load) begin
            r_out_data  <= arr_row_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_row == ROW_LAST);
            if (r_row == ROW_LAST) r_all_issued <= 1'b1;
            else                   r_row        <= r_row + RW'(1);
          end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (w_drain_end) begin
            r_row        <= '0;
            r_all_issued <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Skew lines: lane n is an n-deep shift register advancing only on array fire.
  // Heads read zero outside FEED so FLUSH pushes zeros behind the last beat.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
    logic [INWIDTH-1:0] w_head;
    assign w_head = (r_state == S_FEED) ? bus.in_a[i*INWIDTH +: INWIDTH] : '0;
    if (i == 0) begin : g_pass
      assign arr_a[INWIDTH-1:0] = w_head;
    end else begin : g_line
      logic [i*INWIDTH-1:0]     r_line;
      logic [(i+1)*INWIDTH-1:0] w_shift;
      assign w_shift = {r_line, w_head};
      always_ff @(posedge clk) begin
        if (!rstn || abort) r_line <= '0;
        else if (w_fire)    r_line <= w_shift[i*INWIDTH-1:0];
      end
      assign arr_a[i*INWIDTH +: INWIDTH] = r_line[i*INWIDTH-1 -: INWIDTH];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew_w
    logic [INWIDTH-1:0] w_head;
    assign w_head = (r_state == S_FEED) ? bus.in_w[j*INWIDTH +: INWIDTH] : '0;
    if (j == 0) begin : g_pass
      assign arr_w[INWIDTH-1:0] = w_head;
    end else begin : g_line
      logic [j*INWIDTH-1:0]     r_line;
      logic [(j+1)*INWIDTH-1:0] w_shift;
      assign w_shift = {r_line, w_head};
      always_ff @(posedge clk) begin
        if (!rstn || abort) r_line <= '0;
        else if (w_fire)    r_line <= w_shift[j*INWIDTH-1:0];
      end
      assign arr_w[j*INWIDTH +: INWIDTH] = r_line[j*INWIDTH-1 -: INWIDTH];
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign arr_fire      = w_fire;
  assign arr_clr       = w_clr;
  assign arr_row_sel   = r_row;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
endmodule
